// File: rtl/mcu_channel_scheduler.sv
// mcu_channel_scheduler
//   Merges the per-channel entropy-coder outputs into one code-word stream in
//   MCU order: the whole block of channel 0, then channel 1, ... channel ROW-1,
//   then back to channel 0. Each channel is buffered in its own small FIFO.
//   A full FIFO backpressures its coder. The last word of every MCU is flagged
//   and completed MCUs are counted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous flush (FIFOs, output stage, pointer, count)
//   ch_valid/ch_ready     per-channel input handshake (ready = FIFO not full)
//   ch_code/ch_len/ch_eob per-channel word, channel i in slice i
//   out_valid/out_ready   output handshake of the registered output stage
//   out_code/out_len      code word and its length
//   out_mcu_end           word is the end-of-block word of the last channel
//   cur_ch                channel currently being drained
//   mcu_count             completed MCUs (wrapping)
module mcu_channel_scheduler #(
    parameter int ROW        = 3,
    parameter int CODE_WIDTH = 32,
    parameter int LEN_WIDTH  = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int MCU_CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [ROW-1:0]            ch_valid,
    output logic [ROW-1:0]            ch_ready,
    input  logic [ROW*CODE_WIDTH-1:0] ch_code,
    input  logic [ROW*LEN_WIDTH-1:0]  ch_len,
    input  logic [ROW-1:0]            ch_eob,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CODE_WIDTH-1:0]     out_code,
    output logic [LEN_WIDTH-1:0]      out_len,
    output logic                      out_mcu_end,
    output logic [$clog2(ROW)-1:0]    cur_ch,
    output logic [MCU_CNT_W-1:0]      mcu_count
);
    localparam int CH_W  = $clog2(ROW);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W+1)'(1);
    localparam logic [MCU_CNT_W-1:0] CNT_ONE = MCU_CNT_W'(1);
    localparam logic [CH_W-1:0]    CH_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]    LAST_CH = CH_W'(ROW - 1);

    // FIFO storage (data only, never reset)
    logic [CODE_WIDTH-1:0] mem_code [ROW][FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]  mem_len  [ROW][FIFO_DEPTH];
    logic                  mem_eob  [ROW][FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr [ROW];
    logic [PTR_W:0] rd_ptr [ROW];

    logic [ROW-1:0]        fifo_full;
    logic [ROW-1:0]        fifo_empty;
    logic [ROW-1:0]        wr_en;
    logic [ROW-1:0]        rd_en;
    logic                  head_avail;
    logic [CODE_WIDTH-1:0] head_code;
    logic [LEN_WIDTH-1:0]  head_len;
    logic                  head_eob;
    logic                  load;
    logic [CH_W-1:0]       cur_ch_nxt;

    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                            (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
        end
    end

    // Ready is held low while reset is asserted; writes use the pre-read full
    // flag, so a full FIFO takes nothing even when it is being read.
    assign ch_ready = ~fifo_full & {ROW{rst_n}};
    assign wr_en    = ch_valid & ch_ready & {ROW{~clear}};

    // Head of the FIFO selected by cur_ch; other FIFOs are never read.
    always_comb begin
        head_avail = 1'b0;
        head_code  = '0;
        head_len   = '0;
        head_eob   = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            if (cur_ch == CH_W'(i)) begin
                head_avail = !fifo_empty[i];
                head_code  = mem_code[i][rd_ptr[i][PTR_W-1:0]];
                head_len   = mem_len[i][rd_ptr[i][PTR_W-1:0]];
                head_eob   = mem_eob[i][rd_ptr[i][PTR_W-1:0]];
            end
        end
    end

    assign load = head_avail && (!out_valid || out_ready) && !clear;

    always_comb begin
        for (int i = 0; i < ROW; i++) begin
            rd_en[i] = load && (cur_ch == CH_W'(i));
        end
    end

    assign cur_ch_nxt = (cur_ch == LAST_CH) ? '0 : cur_ch + CH_ONE;

    // ---- FIFO write stage ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROW; i++) begin
            if (wr_en[i]) begin
                mem_code[i][wr_ptr[i][PTR_W-1:0]] <= ch_code[i*CODE_WIDTH +: CODE_WIDTH];
                mem_len[i][wr_ptr[i][PTR_W-1:0]]  <= ch_len[i*LEN_WIDTH +: LEN_WIDTH];
                mem_eob[i][wr_ptr[i][PTR_W-1:0]]  <= ch_eob[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < ROW; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROW; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_len     <= '0;
            out_mcu_end <= 1'b0;
        end else if (clear) begin
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_len     <= '0;
            out_mcu_end <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_code    <= head_code;
            out_len     <= head_len;
            out_mcu_end <= head_eob && (cur_ch == LAST_CH);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // The pointer moves as the end-of-block word is loaded, so the next load
    // (one edge later at the earliest) comes from the following channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch <= '0;
        end else if (clear) begin
            cur_ch <= '0;
        end else if (load && head_eob) begin
            cur_ch <= cur_ch_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcu_count <= '0;
        end else if (clear) begin
            mcu_count <= '0;
        end else if (out_valid && out_ready && out_mcu_end) begin
            mcu_count <= mcu_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mcu_channel_scheduler.sv
`timescale 1ns/1ps
module tb_mcu_channel_scheduler;
    localparam int ROW   = 3;
    localparam int CW    = 32;
    localparam int LW    = 6;
    localparam int DEPTH = 8;
    localparam int MW    = 4;

    typedef struct packed {
        logic [CW-1:0] code;
        logic [LW-1:0] len;
        logic          eob;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [ROW-1:0]    ch_valid;
    logic [ROW-1:0]    ch_ready;
    logic [ROW*CW-1:0] ch_code;
    logic [ROW*LW-1:0] ch_len;
    logic [ROW-1:0]    ch_eob;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_code;
    logic [LW-1:0]     out_len;
    logic              out_mcu_end;
    logic [1:0]        cur_ch;
    logic [MW-1:0]     mcu_count;

    int total = 0;
    int bad   = 0;

    // pend: words waiting to be offered per channel
    // sbq : words accepted by a channel and not yet seen at the output
    word_t pend [ROW][$];
    word_t sbq  [ROW][$];
    int        mch  = 0;
    logic [MW-1:0] emcu = '0;
    int        rdy_mode = 1;
    bit        rand_gap = 1'b0;
    word_t     mw;
    logic      m_end;

    always #5 clk = ~clk;

    mcu_channel_scheduler #(
        .ROW(ROW), .CODE_WIDTH(CW), .LEN_WIDTH(LW),
        .FIFO_DEPTH(DEPTH), .MCU_CNT_W(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_code(ch_code), .ch_len(ch_len), .ch_eob(ch_eob),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_len(out_len), .out_mcu_end(out_mcu_end),
        .cur_ch(cur_ch), .mcu_count(mcu_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input logic [CW-1:0] c, input int l, input bit e);
        word_t w;
        w.code = c;
        w.len  = LW'(l);
        w.eob  = e;
        return w;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < ROW; i++)
            if (pend[i].size() != 0 || sbq[i].size() != 0) return 1'b1;
        return out_valid;
    endfunction

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy() && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy()) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    // Stimulus driver: offers the head of each pend queue, optionally with gaps.
    initial begin
        ch_valid  = '0;
        ch_code   = '0;
        ch_len    = '0;
        ch_eob    = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < ROW; i++) begin
                if (pend[i].size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                    ch_valid[i]          = 1'b1;
                    ch_code[i*CW +: CW]  = pend[i][0].code;
                    ch_len[i*LW +: LW]   = pend[i][0].len;
                    ch_eob[i]            = pend[i][0].eob;
                end else begin
                    ch_valid[i]          = 1'b0;
                    ch_code[i*CW +: CW]  = $urandom;
                    ch_len[i*LW +: LW]   = LW'($urandom);
                    ch_eob[i]            = 1'b1;
                end
            end
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor / scoreboard: the reference stream is "drain channel mch until an
    // eob word, then move to the next channel", applied to accepted words.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n || clear) begin
                for (int i = 0; i < ROW; i++) sbq[i].delete();
                mch  = 0;
                emcu = '0;
            end else begin
                chk("mcu_count", 64'(mcu_count), 64'(emcu));
                for (int i = 0; i < ROW; i++)
                    if (ch_valid[i] && ch_ready[i] && pend[i].size() > 0)
                        sbq[i].push_back(pend[i].pop_front());
                if (out_valid && out_ready) begin
                    if (sbq[mch].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL out_word: got code 0x%0h while serving ch %0d, expected no word", out_code, mch);
                    end else begin
                        mw    = sbq[mch].pop_front();
                        m_end = mw.eob && (mch == ROW - 1);
                        chk("out_word", 64'({out_code, out_len, out_mcu_end}),
                            64'({mw.code, mw.len, m_end}));
                        if (mw.eob) mch = (mch + 1) % ROW;
                        if (m_end) emcu++;
                    end
                end
            end
        end
    end

    initial begin
        word_t w;
        int    n;
        rst_n = 1'b0;
        clear = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 64'(ch_ready), 64'(0));
        chk("valid_in_reset", 64'(out_valid), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // reset in the middle of a stalled stream
        rdy_mode = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) pend[0].push_back(mk(32'h71 + k, 7, k == 2));
        pend[1].push_back(mk(32'h81, 8, 1'b1));
        repeat (6) @(negedge clk);
        chk("stalled_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < ROW; i++) pend[i].delete();
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_code", 64'(out_code), 64'(0));
        chk("midrst_ready", 64'(ch_ready), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1; rdy_mode = 1;
        @(negedge clk);
        chk("rel_valid", 64'(out_valid), 64'(0));
        chk("rel_cur_ch", 64'(cur_ch), 64'(0));
        chk("rel_mcu", 64'(mcu_count), 64'(0));
        chk("rel_ready", 64'(ch_ready), 64'(3'b111));

        // ordering across channels, plus single-cycle latency
        @(negedge clk);
        pend[2].push_back(mk(32'h5, 3, 1'b1));
        pend[1].push_back(mk(32'h3, 2, 1'b1));
        pend[0].push_back(mk(32'h1, 1, 1'b0));
        pend[0].push_back(mk(32'h2, 2, 1'b1));
        @(negedge clk);
        @(negedge clk);
        chk("lat_not_yet", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_valid", 64'({out_valid, out_code}), 64'({1'b1, 32'h1}));
        wait_idle("order_idle", 200);
        chk("order_mcu", 64'(mcu_count), 64'(1));
        chk("order_cur_ch", 64'(cur_ch), 64'(0));

        // backpressure: 8 in the FIFO + 1 in the output register
        rdy_mode = 0;
        pulse_clear();
        @(negedge clk);
        for (int k = 0; k < 10; k++) pend[0].push_back(mk(32'h100 + k, 9, 1'b0));
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold", 64'({out_valid, out_code}), 64'({1'b1, 32'h100}));
        end
        chk("bp_accepted", 64'(10 - pend[0].size()), 64'(9));
        chk("bp_ready", 64'(ch_ready), 64'(3'b110));
        rdy_mode = 1;
        wait_idle("bp_idle", 200);
        chk("bp_cur_ch", 64'(cur_ch), 64'(0));

        // starvation: channel 1 silent
        pulse_clear();
        @(negedge clk);
        pend[0].push_back(mk(32'hA, 4, 1'b1));
        for (int k = 0; k < DEPTH; k++) pend[2].push_back(mk(32'h200 + k, 10, k == DEPTH - 1));
        repeat (20) @(negedge clk);
        chk("starve_valid", 64'(out_valid), 64'(0));
        chk("starve_cur_ch", 64'(cur_ch), 64'(1));
        chk("starve_ready", 64'(ch_ready), 64'(3'b011));
        chk("starve_ch2_taken", 64'(pend[2].size()), 64'(0));
        pend[1].push_back(mk(32'hB, 4, 1'b1));
        wait_idle("starve_idle", 200);
        chk("starve_mcu", 64'(mcu_count), 64'(1));
        chk("starve_cur_ch_end", 64'(cur_ch), 64'(0));

        // clear in the middle of an MCU
        pulse_clear();
        @(negedge clk);
        pend[0].push_back(mk(32'h11, 5, 1'b1));
        for (int k = 0; k < 3; k++) pend[2].push_back(mk(32'h30 + k, 6, k == 2));
        repeat (8) @(negedge clk);
        chk("pre_clr_cur_ch", 64'(cur_ch), 64'(1));
        pulse_clear();
        @(negedge clk);
        chk("clr_valid", 64'(out_valid), 64'(0));
        chk("clr_cur_ch", 64'(cur_ch), 64'(0));
        chk("clr_ready", 64'(ch_ready), 64'(3'b111));
        chk("clr_mcu", 64'(mcu_count), 64'(0));
        pend[0].push_back(mk(32'h12, 5, 1'b1));
        pend[1].push_back(mk(32'h13, 5, 1'b1));
        pend[2].push_back(mk(32'h14, 0, 1'b1));
        wait_idle("clr_idle", 200);
        chk("clr_mcu_after", 64'(mcu_count), 64'(1));

        // counter wrap at 2^MW
        pulse_clear();
        @(negedge clk);
        for (int k = 0; k < 17; k++)
            for (int i = 0; i < ROW; i++) pend[i].push_back(mk(32'(k * 16 + i), 3, 1'b1));
        wait_idle("wrap_idle", 600);
        chk("wrap_mcu", 64'(mcu_count), 64'(1));

        // randomized blocks, gaps and downstream stalls
        pulse_clear();
        rand_gap = 1'b1;
        rdy_mode = 2;
        @(negedge clk);
        for (int m = 0; m < 31; m++) begin
            for (int i = 0; i < ROW; i++) begin
                n = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    w = mk($urandom, $urandom_range(0, 32), j == n - 1);
                    if (j == n - 1 && $urandom_range(0, 3) == 0) w.len = '0;
                    pend[i].push_back(w);
                end
            end
        end
        wait_idle("rand_idle", 20000);
        chk("rand_mcu", 64'(mcu_count), 64'(31 % 16));
        rand_gap = 1'b0;
        rdy_mode = 1;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
